// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

  // Clear engine state: sweeping entries to zero, or serving reads/writes.
  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NUM_RD = 2;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear engine: walks every entry once after reset or a clear request,
// then reports ready. Owns the sweep state, the sweep index and ready.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_req,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  rf_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic              ready_reg;

  // State, index and ready registers; ready tracks the state being entered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= RF_CLEAR;
      idx_reg   <= '0;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      ready_reg <= (state_next == RF_READY);
    end
  end

  // Next-state: sweep one entry per edge; a clear request restarts only from ready.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      RF_CLEAR: begin
        idx_next = idx_reg + 1'b1;
        if (idx_reg == LAST_IDX) begin
          state_next = RF_READY;
        end
      end
      RF_READY: begin
        if (clear_req) begin
          state_next = RF_CLEAR;
          idx_next   = '0;
        end
      end
      default: begin
        state_next = RF_CLEAR;
        idx_next   = '0;
      end
    endcase
  end

  // No entry is touched while reset is held, only during a live sweep.
  assign clr_en   = reset_n && (state_reg == RF_CLEAR);
  assign clr_addr = idx_reg;
  assign ready    = ready_reg;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file: one synchronous write port, NUM_RD
// combinational read ports with write-to-read bypass, optional hardwired
// zero entry, and a sequential clear sweep gating access via ready.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clear_req,
  output logic                     ready
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_zero_drop;
  logic              wr_ok;

  regfile_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_req (clear_req),
    .clr_en    (clr_en),
    .clr_addr  (clr_addr),
    .ready     (ready)
  );

  // A port write lands only when ready and not aimed at the hardwired zero.
  assign wr_zero_drop = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_ok        = wr_en && ready && !wr_zero_drop;

  // Storage update: the sweep has priority; it never overlaps a port write.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem_reg[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;

    assign addr = rd_addr[gi*ADDR_W +: ADDR_W];
    // Blank during sweep, zero for the hardwired entry, else bypass or stored.
    assign val  = !ready                              ? '0      :
                  ((ZERO_REG != 0) && (addr == '0))   ? '0      :
                  (wr_ok && (wr_addr == addr))        ? wr_data :
                                                        mem_reg[addr];
    assign rd_data[gi*DATA_W +: DATA_W] = val;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default 2R 32x32 instance plus a
// 4R 8x64 instance without the zero entry, checked against an abstract model.
module tb_regfile_mp;

  localparam int AW_A = 5, DW_A = 32, NR_A = 2;
  localparam int AW_B = 3, DW_B = 64, NR_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n_a, wr_en_a, clear_req_a, ready_a;
  logic [AW_A-1:0]      wr_addr_a;
  logic [DW_A-1:0]      wr_data_a;
  logic [NR_A*AW_A-1:0] rd_addr_a;
  logic [NR_A*DW_A-1:0] rd_data_a;

  logic                 rst_n_b, wr_en_b, clear_req_b, ready_b;
  logic [AW_B-1:0]      wr_addr_b;
  logic [DW_B-1:0]      wr_data_b;
  logic [NR_B*AW_B-1:0] rd_addr_b;
  logic [NR_B*DW_B-1:0] rd_data_b;

  int total = 0;
  int bad   = 0;

  regfile_mp #(.DATA_W(DW_A), .ADDR_W(AW_A), .NUM_RD(NR_A), .ZERO_REG(1)) dut_a (
    .clk(clk), .reset_n(rst_n_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .clear_req(clear_req_a), .ready(ready_a));

  regfile_mp #(.DATA_W(DW_B), .ADDR_W(AW_B), .NUM_RD(NR_B), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset_n(rst_n_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .clear_req(clear_req_b), .ready(ready_b));

  // Reference model: contents, availability, and edges left in the sweep.
  logic [63:0] m_mem [2][32];
  bit          m_ready [2];
  int          m_cnt [2];

  function automatic int depth_of(input int k);
    return (k == 0) ? 32 : 8;
  endfunction

  function automatic bit zr_of(input int k);
    return (k == 0);
  endfunction

  task automatic model_edge(input int k, input bit rst, input bit we, input int wa,
                            input logic [63:0] wd, input bit cr);
    if (!rst) begin
      m_ready[k] = 1'b0;
      m_cnt[k]   = depth_of(k);
    end else if (!m_ready[k]) begin
      m_cnt[k] = m_cnt[k] - 1;
      if (m_cnt[k] == 0) begin
        for (int j = 0; j < 32; j++) m_mem[k][j] = '0;
        m_ready[k] = 1'b1;
      end
    end else begin
      if (we && !(zr_of(k) && wa == 0)) m_mem[k][wa] = wd;
      if (cr) begin
        m_ready[k] = 1'b0;
        m_cnt[k]   = depth_of(k);
      end
    end
  endtask

  function automatic logic [63:0] exp_rd(input int k, input int ra, input bit we,
                                         input int wa, input logic [63:0] wd);
    if (!m_ready[k]) return '0;
    if (zr_of(k) && ra == 0) return '0;
    if (we && ra == wa) return wd;
    return m_mem[k][ra];
  endfunction

  initial begin
    m_ready[0] = 1'b0; m_ready[1] = 1'b0;
    m_cnt[0] = 32;     m_cnt[1] = 8;
  end

  always @(posedge clk) begin
    model_edge(0, rst_n_a, wr_en_a, int'(wr_addr_a), 64'(wr_data_a), clear_req_a);
    model_edge(1, rst_n_b, wr_en_b, int'(wr_addr_b), wr_data_b, clear_req_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n_a = 1'b0;
    repeat (3) tick();
    total++;
    if (ready_a !== 1'b0 || rd_data_a !== '0) begin
      bad++;
      $display("FAIL reset_hold ready=%b rd=%h required ready=0 rd=0", ready_a, rd_data_a);
    end
    rst_n_a = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      tick();
      total++;
      if (ready_a !== (e == 32)) begin
        bad++;
        $display("FAIL reset_ready edge=%0d got=%b required=%b", e, ready_a, (e == 32));
      end
    end
    for (int a = 0; a < 32; a++) begin
      rd_addr_a = {5'(31 - a), 5'(a)};
      #1;
      total++;
      if (rd_data_a !== '0) begin
        bad++;
        $display("FAIL reset_zero addr=%0d got=%h required=0", a, rd_data_a);
      end
    end
    $display("reset: released, ready after 32 edges, all entries read back");
  endtask

  task automatic test_write_read();
    wr_en_a = 1'b1; wr_addr_a = 5; wr_data_a = 32'hDEADBEEF;
    tick();
    wr_en_a = 1'b0; rd_addr_a = {5'd5, 5'd5};
    #1;
    total++;
    if (rd_data_a !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL write_x5 got=%h required=deadbeefdeadbeef", rd_data_a);
    end
    $display("write x5=deadbeef read both ports=%h", rd_data_a);
    wr_en_a = 1'b1; wr_addr_a = 0; wr_data_a = 32'h1234;
    tick();
    wr_en_a = 1'b0; rd_addr_a = '0;
    #1;
    total++;
    if (rd_data_a !== '0) begin
      bad++;
      $display("FAIL write_x0 got=%h required=0", rd_data_a);
    end
    $display("write x0=1234 read both ports=%h", rd_data_a);
  endtask

  task automatic test_bypass();
    logic [31:0] old8;
    old8 = $urandom;
    wr_en_a = 1'b1; wr_addr_a = 8; wr_data_a = old8;
    tick();
    wr_en_a = 1'b1; wr_addr_a = 7; wr_data_a = 32'hFFFFFF0B;
    rd_addr_a = {5'd8, 5'd7};
    #1;
    total++;
    if (rd_data_a[31:0] !== 32'hFFFFFF0B || rd_data_a[63:32] !== old8) begin
      bad++;
      $display("FAIL bypass got=%h required=%h_ffffff0b", rd_data_a, old8);
    end
    $display("bypass x7=ffffff0b port0=%h port1(x8)=%h", rd_data_a[31:0], rd_data_a[63:32]);
    tick();
    wr_en_a = 1'b0;
  endtask

  task automatic test_random();
    int ra0, ra1;
    logic [63:0] e0, e1;
    for (int n = 0; n < 100; n++) begin
      wr_en_a   = $urandom_range(0, 1);
      wr_addr_a = 5'($urandom_range(0, 31));
      wr_data_a = $urandom;
      ra0 = (n % 4 == 0) ? int'(wr_addr_a) : int'($urandom_range(0, 31));
      ra1 = int'($urandom_range(0, 31));
      rd_addr_a = {5'(ra1), 5'(ra0)};
      #1;
      e0 = exp_rd(0, ra0, wr_en_a, int'(wr_addr_a), 64'(wr_data_a));
      e1 = exp_rd(0, ra1, wr_en_a, int'(wr_addr_a), 64'(wr_data_a));
      total++;
      if (64'(rd_data_a[31:0]) !== e0 || 64'(rd_data_a[63:32]) !== e1) begin
        bad++;
        $display("FAIL random n=%0d addr=%0d/%0d got=%h required=%h_%h",
                 n, ra0, ra1, rd_data_a, e1[31:0], e0[31:0]);
      end
      $display("random n=%0d we=%b wa=%0d wd=%h ra=%0d/%0d rd=%h",
               n, wr_en_a, wr_addr_a, wr_data_a, ra0, ra1, rd_data_a);
      tick();
    end
    wr_en_a = 1'b0;
  endtask

  task automatic test_clear();
    wr_en_a = 1'b1; wr_addr_a = 3; wr_data_a = 32'hA5; clear_req_a = 1'b1;
    tick();
    clear_req_a = 1'b0;
    wr_addr_a = 9; wr_data_a = 32'h0BAD_F00D;
    rd_addr_a = {5'd9, 5'd3};
    #1;
    total++;
    if (ready_a !== 1'b0 || rd_data_a !== '0) begin
      bad++;
      $display("FAIL clear_start ready=%b rd=%h required ready=0 rd=0", ready_a, rd_data_a);
    end
    for (int e = 1; e <= 32; e++) begin
      tick();
      wr_en_a = 1'b0;
      total++;
      if (ready_a !== (e == 32)) begin
        bad++;
        $display("FAIL clear_ready edge=%0d got=%b required=%b", e, ready_a, (e == 32));
      end
    end
    #1;
    total++;
    if (rd_data_a !== '0) begin
      bad++;
      $display("FAIL clear_zero x3/x9 got=%h required=0", rd_data_a);
    end
    $display("clear with write x3=a5, write x9 during sweep, after sweep rd=%h", rd_data_a);
  endtask

  task automatic test_reset_mid();
    for (int a = 1; a < 32; a++) begin
      wr_en_a = 1'b1; wr_addr_a = 5'(a); wr_data_a = $urandom | 32'h1;
      tick();
    end
    wr_en_a = 1'b0; clear_req_a = 1'b1;
    tick();
    clear_req_a = 1'b0;
    repeat (17) tick();
    rst_n_a = 1'b0;
    tick();
    rst_n_a = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      tick();
      total++;
      if (ready_a !== (e == 32)) begin
        bad++;
        $display("FAIL midreset_ready edge=%0d got=%b required=%b", e, ready_a, (e == 32));
      end
    end
    for (int a = 0; a < 32; a++) begin
      rd_addr_a = {5'(a), 5'(a)};
      #1;
      total++;
      if (rd_data_a !== '0) begin
        bad++;
        $display("FAIL midreset_zero addr=%0d got=%h required=0", a, rd_data_a);
      end
    end
    $display("reset at sweep idx 17: full 32-edge sweep, all entries zero");
  endtask

  task automatic test_params();
    int ra [NR_B];
    logic [63:0] ex;
    rst_n_b = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      total++;
      if (ready_b !== (e == 8)) begin
        bad++;
        $display("FAIL b_ready edge=%0d got=%b required=%b", e, ready_b, (e == 8));
      end
    end
    wr_en_b = 1'b1; wr_addr_b = 0; wr_data_b = 64'h1;
    tick();
    wr_en_b = 1'b0; rd_addr_b = '0;
    #1;
    total++;
    if (rd_data_b[63:0] !== 64'h1) begin
      bad++;
      $display("FAIL b_entry0 got=%h required=1", rd_data_b[63:0]);
    end
    $display("b: write entry0=1 read=%h", rd_data_b[63:0]);
    for (int a = 1; a < 8; a++) begin
      wr_en_b = 1'b1; wr_addr_b = 3'(a); wr_data_b = {$urandom, $urandom};
      tick();
    end
    for (int n = 0; n < 30; n++) begin
      wr_en_b   = $urandom_range(0, 1);
      wr_addr_b = 3'($urandom_range(0, 7));
      wr_data_b = {$urandom, $urandom};
      for (int p = 0; p < NR_B; p++) begin
        ra[p] = (n < 2) ? p * 2 + n : int'($urandom_range(0, 7));
        rd_addr_b[p*AW_B +: AW_B] = 3'(ra[p]);
      end
      #1;
      for (int p = 0; p < NR_B; p++) begin
        ex = exp_rd(1, ra[p], wr_en_b, int'(wr_addr_b), wr_data_b);
        total++;
        if (rd_data_b[p*DW_B +: DW_B] !== ex) begin
          bad++;
          $display("FAIL b_port n=%0d port=%0d addr=%0d got=%h required=%h",
                   n, p, ra[p], rd_data_b[p*DW_B +: DW_B], ex);
        end
      end
      $display("b: n=%0d we=%b wa=%0d addrs=%0d,%0d,%0d,%0d", n, wr_en_b, wr_addr_b,
               ra[0], ra[1], ra[2], ra[3]);
      tick();
    end
    wr_en_b = 1'b0;
  endtask

  initial begin
    rst_n_a = 1'b0; wr_en_a = 1'b0; clear_req_a = 1'b0;
    wr_addr_a = '0; wr_data_a = '0; rd_addr_a = '0;
    rst_n_b = 1'b0; wr_en_b = 1'b0; clear_req_b = 1'b0;
    wr_addr_b = '0; wr_data_b = '0; rd_addr_b = '0;
    tick();
    test_reset();
    test_write_read();
    test_bypass();
    test_random();
    test_clear();
    test_reset_mid();
    test_random();
    test_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
